kianv_sc_mem_bridge: RTL

- Sits directly downstream of the single-cycle rv32im core's data port (PC/Instr side untouched).
- Converts the core's combinational load/store (address, write data, byte mask, read data) into a registered valid/ready request on the system bus.
- Generates a stall that gates the core's clock enable until the access completes, so the core works with multi-cycle memories and MMIO.

---
 rtl/kianv_sc_mem_bridge.sv | 108 ++++++++++
 1 files changed

// File: rtl/kianv_sc_mem_bridge.sv
// Data-port bridge between the single-cycle kianv core and a valid/ready bus.
// Optional wait-state timeout is compiled in with `define KIANV_MEM_BRIDGE_TIMEOUT_EN.
module kianv_sc_mem_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] TIMEOUT_RDATA  = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        cpu_req,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [3:0]  cpu_wmask,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   output logic        timeout
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;

   // The core only advances on the DONE cycle; reset also releases it.
   assign cpu_stall = resetn & cpu_req & (state != DONE);

`ifdef KIANV_MEM_BRIDGE_TIMEOUT_EN
   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] wait_cnt;
   logic          unused_sig;

   assign unused_sig = ^cpu_addr[1:0];
`else
   logic unused_sig;

   assign unused_sig = ^{cpu_addr[1:0], TIMEOUT_CYCLES, TIMEOUT_RDATA};
   assign timeout    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= IDLE;
         mem_valid <= 1'b0;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;
         mem_wstrb <= 4'd0;
         cpu_rdata <= 32'd0;
`ifdef KIANV_MEM_BRIDGE_TIMEOUT_EN
         wait_cnt  <= '0;
         timeout   <= 1'b0;
`endif
      end else begin
`ifdef KIANV_MEM_BRIDGE_TIMEOUT_EN
         timeout <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (cpu_req) begin
                  mem_addr  <= {cpu_addr[31:2], 2'b00};
                  mem_wdata <= cpu_wdata;
                  mem_wstrb <= cpu_wmask;
                  mem_valid <= 1'b1;
`ifdef KIANV_MEM_BRIDGE_TIMEOUT_EN
                  wait_cnt  <= '0;
`endif
                  state     <= REQ;
               end
            end
            REQ: begin
               // mem_ready wins over a timeout landing in the same cycle.
               if (mem_ready) begin
                  cpu_rdata <= mem_rdata;
                  mem_valid <= 1'b0;
                  state     <= DONE;
               end
`ifdef KIANV_MEM_BRIDGE_TIMEOUT_EN
               else if (wait_cnt == WAIT_LAST) begin
                  cpu_rdata <= TIMEOUT_RDATA;
                  mem_valid <= 1'b0;
                  timeout   <= 1'b1;
                  state     <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state     <= IDLE;
               mem_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
